// File: rtl/dqpsk_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dqpsk_pkg
// Purpose  : Shared DQPSK quadrant and Gray dibit maps plus decoder state type.
// Revision : 1.0  initial release
// ============================================================================
package dqpsk_pkg;

   typedef enum logic [0:0] {
      WAIT_REF = 1'b0,
      RUN      = 1'b1
   } dec_state_t;

   // (i_neg,q_neg) sign pair to quadrant index, counter-clockwise from quadrant 0
   function automatic logic [1:0] quadrant(input logic i_n, input logic q_n);
      logic [1:0] w_quad;
      case ({i_n, q_n})
         2'b00:   w_quad = 2'd0;
         2'b10:   w_quad = 2'd1;
         2'b11:   w_quad = 2'd2;
         default: w_quad = 2'd3;
      endcase
      return w_quad;
   endfunction

   function automatic logic [1:0] gray_dibit(input logic [1:0] delta);
      logic [1:0] w_bits;
      case (delta)
         2'd0:    w_bits = 2'b00;
         2'd1:    w_bits = 2'b01;
         2'd2:    w_bits = 2'b11;
         default: w_bits = 2'b10;
      endcase
      return w_bits;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dibit_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dibit_fifo
// Purpose  : Synchronous 2-bit-wide FIFO; a push on a full FIFO is accepted only
//            when a pop happens in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module dibit_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic [1:0] i_wr_data,
   output logic [1:0] o_rd_data,
   output logic       o_full,
   output logic       o_empty
);

   localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [1:0]      r_mem [DEPTH];
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_rd_ptr;
   logic [c_aw:0]   r_count;
   logic            w_push_ok;
   logic            w_pop_ok;

   assign o_full    = (r_count == (c_aw+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_rd_data = r_mem[r_rd_ptr];
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!o_full || w_pop_ok);

   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         r_mem[r_wr_ptr] <= i_wr_data;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_wr_ptr <= r_wr_ptr + c_aw'(1);
         end
         if (w_pop_ok) begin
            r_rd_ptr <= r_rd_ptr + c_aw'(1);
         end
         case ({w_push_ok, w_pop_ok})
            2'b10:   r_count <= r_count + (c_aw+1)'(1);
            2'b01:   r_count <= r_count - (c_aw+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/dqpsk_diff_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dqpsk_diff_decoder
// Purpose  : Recovers Gray dibits from DQPSK quadrant differences and streams
//            them MSB-first over valid/ready; drops the reference on symbol loss.
// Revision : 1.0  initial release
// ============================================================================
module dqpsk_diff_decoder
   import dqpsk_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk_dds,
   input  logic rstn,
   input  logic sym_valid,
   input  logic i_neg,
   input  logic q_neg,
   output logic bit_out,
   output logic bit_valid,
   input  logic bit_ready,
   output logic locked,
   output logic overflow
);

   localparam int c_cnt_w = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [c_cnt_w-1:0] c_tcnt_max = c_cnt_w'(TIMEOUT_CYC - 1);

   dec_state_t         r_state;
   dec_state_t         w_next_state;
   logic [c_cnt_w-1:0] r_tcnt;
   logic [1:0]         r_prev_q;
   logic [1:0]         w_q;
   logic [1:0]         w_delta;
   logic [1:0]         w_dibit;
   logic [1:0]         w_fifo_rd;
   logic               w_timeout;
   logic               w_push;
   logic               w_pop;
   logic               w_full;
   logic               w_empty;
   logic               r_busy;
   logic               r_phase;
   logic [1:0]         r_dibit;
   logic               r_overflow;

   assign w_q       = quadrant(i_neg, q_neg);
   assign w_delta   = w_q - r_prev_q;
   assign w_dibit   = gray_dibit(w_delta);
   assign w_timeout = (r_tcnt == c_tcnt_max);

   always_ff @(posedge clk_dds or negedge rstn) begin
      if (!rstn) begin
         r_state <= WAIT_REF;
      end else begin
         r_state <= w_next_state;
      end
   end

   // A symbol arriving on the timeout cycle keeps the reference alive
   always_comb begin
      w_next_state = r_state;
      w_push       = 1'b0;
      case (r_state)
         WAIT_REF: begin
            if (sym_valid) begin
               w_next_state = RUN;
            end
         end
         RUN: begin
            if (sym_valid) begin
               w_push = 1'b1;
            end else if (w_timeout) begin
               w_next_state = WAIT_REF;
            end
         end
         default: w_next_state = WAIT_REF;
      endcase
   end

   always_ff @(posedge clk_dds or negedge rstn) begin
      if (!rstn) begin
         r_tcnt     <= '0;
         r_prev_q   <= 2'd0;
         r_overflow <= 1'b0;
      end else begin
         if ((r_state == RUN) && !sym_valid && !w_timeout) begin
            r_tcnt <= r_tcnt + c_cnt_w'(1);
         end else begin
            r_tcnt <= '0;
         end
         // Reference advances even when the dibit is dropped, so phase stays correct
         if (sym_valid) begin
            r_prev_q <= w_q;
         end
         if (w_push && w_full && !w_pop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   dibit_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk_dds),
      .rstn      (rstn),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_wr_data (w_dibit),
      .o_rd_data (w_fifo_rd),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   // Reload on the LSB handshake so consecutive dibits stream without a gap
   assign w_pop = !w_empty && (!r_busy || (r_phase && bit_ready));

   always_ff @(posedge clk_dds or negedge rstn) begin
      if (!rstn) begin
         r_busy  <= 1'b0;
         r_phase <= 1'b0;
         r_dibit <= 2'b00;
      end else if (w_pop) begin
         r_busy  <= 1'b1;
         r_phase <= 1'b0;
         r_dibit <= w_fifo_rd;
      end else if (r_busy && bit_ready) begin
         if (!r_phase) begin
            r_phase <= 1'b1;
         end else begin
            r_busy  <= 1'b0;
            r_phase <= 1'b0;
         end
      end
   end

   assign bit_out   = r_phase ? r_dibit[0] : r_dibit[1];
   assign bit_valid = r_busy;
   assign locked    = (r_state == RUN);
   assign overflow  = r_overflow;

endmodule
`default_nettype wire
